wavegrp_tracker: RTL and testbench

//  Parametrised workgroup bookkeeping for the issue stage.
//  - Maps each resident wavefront slot to its workgroup id (wgid = wfid of the group's first/leader wavefront) and group size.
//  - Counts halts per group; pulses wg_done when the last member halts, then frees the group entry.
//  - Optionally counts barrier arrivals per group and pulses a release.

---
 rtl/wavegrp_tracker_pkg.sv | 19 +
 rtl/wavegrp_tracker_if.sv | 47 ++++
 rtl/wavegrp_tracker_cam.sv | 27 ++
 rtl/wavegrp_tracker.sv | 218 +++++++++++++++++++++
 tb/tb_wavegrp_tracker.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavegrp_tracker_pkg.sv
// Shared definitions for the workgroup tracker: default widths and the
// allocate decision encoding used by the top level.
package wavegrp_tracker_pkg;

    localparam int DEF_NUM_WF   = 40;
    localparam int DEF_WFID_W   = 6;
    localparam int DEF_TAG_W    = 15;
    localparam int DEF_WG_TAG_W = 11;
    localparam int DEF_CNT_W    = 4;

    // Outcome of an allocate request in the current cycle.
    typedef enum logic [1:0] {
        ALLOC_NONE = 2'd0,
        ALLOC_HIT  = 2'd1,
        ALLOC_MISS = 2'd2,
        ALLOC_ERR  = 2'd3
    } alloc_kind_e;

endpackage

// File: rtl/wavegrp_tracker_if.sv
// Bus bundle between the issue stage and the workgroup tracker.
// Handshake: there is no back-pressure. wf_wr_en, halt and barrier_en are
// single-cycle command strobes that qualify their id/data fields in the
// cycle they are high; wg_done, wr_err and barrier_release are single-cycle
// result strobes qualifying their id fields. rd_* is a free-running lookup
// with one cycle of latency.
interface wavegrp_tracker_if
    import wavegrp_tracker_pkg::*;
#(
    parameter int WFID_W = DEF_WFID_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              wf_wr_en;
    logic [WFID_W-1:0] wr_wfid;
    logic [TAG_W-1:0]  wr_wf_tag;
    logic [CNT_W-1:0]  wr_wg_wf_count;
    logic              halt;
    logic [WFID_W-1:0] halt_wfid;
    logic [WFID_W-1:0] rd_wfid;
    logic              rd_valid;
    logic [WFID_W-1:0] rd_wgid;
    logic [CNT_W-1:0]  rd_wf_count;
    logic              wg_done;
    logic [WFID_W-1:0] wg_done_wgid;
    logic              wr_err;
    logic              barrier_en;
    logic [WFID_W-1:0] barrier_wfid;
    logic              barrier_release;
    logic [WFID_W-1:0] barrier_wgid;

    modport master (
        output wf_wr_en, wr_wfid, wr_wf_tag, wr_wg_wf_count, halt, halt_wfid,
               rd_wfid, barrier_en, barrier_wfid,
        input  rd_valid, rd_wgid, rd_wf_count, wg_done, wg_done_wgid, wr_err,
               barrier_release, barrier_wgid
    );

    modport slave (
        input  wf_wr_en, wr_wfid, wr_wf_tag, wr_wg_wf_count, halt, halt_wfid,
               rd_wfid, barrier_en, barrier_wfid,
        output rd_valid, rd_wgid, rd_wf_count, wg_done, wg_done_wgid, wr_err,
               barrier_release, barrier_wgid
    );

endinterface

// File: rtl/wavegrp_tracker_cam.sv
// Group key CAM: compares one key against every live group entry and
// returns the lowest matching entry index.
module wavegrp_tracker_cam #(
    parameter int NUM   = 40,
    parameter int KEY_W = 11,
    parameter int IDX_W = 6
) (
    input  logic [KEY_W-1:0] key,
    input  logic [NUM-1:0]   ent_valid,
    input  logic [KEY_W-1:0] ent_key [NUM],
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan high to low so the lowest matching index is the one kept.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_key[i] == key)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wavegrp_tracker.sv
// Workgroup bookkeeping for the issue stage: slot -> workgroup mapping,
// per-group halt counting with a completion pulse, optional barrier counting.
// Build option: define WAVEGRP_BARRIER_EN to build the barrier counters;
// without it the barrier outputs are tied to 0 and the inputs are ignored.
module wavegrp_tracker
    import wavegrp_tracker_pkg::*;
#(
    parameter int NUM_WF   = DEF_NUM_WF,
    parameter int WFID_W   = DEF_WFID_W,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int WG_TAG_W = DEF_WG_TAG_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    wavegrp_tracker_if.slave bus
);

    // Slot table and group table (group entries live at the leader's index).
    logic [NUM_WF-1:0]   slot_valid;
    logic [WFID_W-1:0]   slot_wgid [NUM_WF];
    logic [NUM_WF-1:0]   gvalid, gvalid_n;
    logic [WG_TAG_W-1:0] gtag [NUM_WF];
    logic [CNT_W-1:0]    gcount [NUM_WF];
    logic [CNT_W-1:0]    ghalted [NUM_WF];
    logic [CNT_W-1:0]    ghalted_n [NUM_WF];

    logic [WG_TAG_W-1:0] wr_key;
    logic                w_inr, h_inr, r_inr, r_valid;
    logic                h_ok, h_done, h_sel;
    logic [WFID_W-1:0]   h_grp;
    logic [CNT_W:0]      h_cnt, hal_s, cnt_s;
    logic [NUM_WF-1:0]   done_mask, cam_valid;
    logic                cam_hit, w_busy, g_busy;
    logic [WFID_W-1:0]   cam_idx, w_wgid;
    alloc_kind_e         a_kind;
    logic                unused_bits;

    assign wr_key = bus.wr_wf_tag[TAG_W-1 -: WG_TAG_W];
    assign w_inr  = {1'b0, bus.wr_wfid}   < (WFID_W + 1)'(NUM_WF);
    assign h_inr  = {1'b0, bus.halt_wfid} < (WFID_W + 1)'(NUM_WF);
    assign r_inr  = {1'b0, bus.rd_wfid}   < (WFID_W + 1)'(NUM_WF);

    // Halt side: the retiring slot's group and whether this halt finishes it.
    assign h_ok   = bus.halt && h_inr && slot_valid[bus.halt_wfid];
    assign h_grp  = slot_wgid[bus.halt_wfid];
    assign h_cnt  = {1'b0, ghalted[h_grp]} + {{CNT_W{1'b0}}, 1'b1};
    assign h_done = h_ok && (h_cnt >= {1'b0, gcount[h_grp]});

    // A group completing this cycle must not absorb a new member.
    assign done_mask = h_done ? (NUM_WF'(1) << h_grp) : '0;
    assign cam_valid = gvalid & ~done_mask;

    wavegrp_tracker_cam #(
        .NUM   (NUM_WF),
        .KEY_W (WG_TAG_W),
        .IDX_W (WFID_W)
    ) u_cam (
        .key       (wr_key),
        .ent_valid (cam_valid),
        .ent_key   (gtag),
        .hit       (cam_hit),
        .idx       (cam_idx)
    );

    // A same-cycle halt frees the slot and possibly the group entry first.
    assign w_busy = slot_valid[bus.wr_wfid] && !(h_ok && (bus.halt_wfid == bus.wr_wfid));
    assign g_busy = gvalid[bus.wr_wfid] && !(h_done && (h_grp == bus.wr_wfid));
    assign w_wgid = (a_kind == ALLOC_HIT) ? cam_idx : bus.wr_wfid;

    // Classify the allocate request; out-of-range slots are rejected too.
    always_comb begin
        a_kind = ALLOC_NONE;
        if (bus.wf_wr_en) begin
            if (!w_inr || w_busy) begin
                a_kind = ALLOC_ERR;
            end else if (cam_hit) begin
                a_kind = ALLOC_HIT;
            end else if ((bus.wr_wg_wf_count == '0) || g_busy) begin
                a_kind = ALLOC_ERR;
            end else begin
                a_kind = ALLOC_MISS;
            end
        end
    end

`ifdef WAVEGRP_BARRIER_EN
    logic [CNT_W-1:0]  garrive [NUM_WF];
    logic [CNT_W-1:0]  garrive_n [NUM_WF];
    logic              b_ok, b_sel, rel_hit;
    logic [WFID_W-1:0] b_grp, rel_grp;
    logic [CNT_W:0]    arr_s;

    assign b_ok  = bus.barrier_en && ({1'b0, bus.barrier_wfid} < (WFID_W + 1)'(NUM_WF))
                   && slot_valid[bus.barrier_wfid];
    assign b_grp = slot_wgid[bus.barrier_wfid];
    assign unused_bits = ^bus.wr_wf_tag;
`else
    assign unused_bits = ^{bus.wr_wf_tag, bus.barrier_en, bus.barrier_wfid};
    assign bus.barrier_release = 1'b0;
    assign bus.barrier_wgid    = '0;
`endif

    // Next group-table state: halt counting, completion, barrier, new group.
    always_comb begin
        gvalid_n = gvalid;
        h_sel    = 1'b0;
        hal_s    = '0;
        cnt_s    = '0;
`ifdef WAVEGRP_BARRIER_EN
        b_sel   = 1'b0;
        arr_s   = '0;
        rel_hit = 1'b0;
        rel_grp = '0;
`endif
        for (int g = 0; g < NUM_WF; g++) begin
            h_sel        = h_ok && (h_grp == WFID_W'(g));
            cnt_s        = {1'b0, gcount[g]};
            hal_s        = h_sel ? h_cnt : {1'b0, ghalted[g]};
            ghalted_n[g] = hal_s[CNT_W-1:0];
`ifdef WAVEGRP_BARRIER_EN
            b_sel = b_ok && (b_grp == WFID_W'(g));
            arr_s = {1'b0, garrive[g]} + {{CNT_W{1'b0}}, b_sel};
            if (arr_s > cnt_s) begin
                arr_s = cnt_s;
            end
            garrive_n[g] = arr_s[CNT_W-1:0];
            // Halted members count as arrived; a completing group reports
            // wg_done only. Lowest index wins if two groups release at once.
            if (gvalid[g] && (h_sel || b_sel) && (arr_s != '0) && ((arr_s + hal_s) >= cnt_s)) begin
                garrive_n[g] = '0;
                if (!(h_sel && h_done) && !rel_hit) begin
                    rel_hit = 1'b1;
                    rel_grp = WFID_W'(g);
                end
            end
`endif
            if (h_sel && h_done) begin
                gvalid_n[g]  = 1'b0;
                ghalted_n[g] = '0;
`ifdef WAVEGRP_BARRIER_EN
                garrive_n[g] = '0;
`endif
            end
            if ((a_kind == ALLOC_MISS) && (bus.wr_wfid == WFID_W'(g))) begin
                gvalid_n[g]  = 1'b1;
                ghalted_n[g] = '0;
`ifdef WAVEGRP_BARRIER_EN
                garrive_n[g] = '0;
`endif
            end
        end
    end

    assign r_valid = r_inr && slot_valid[bus.rd_wfid];

    // Table update, registered lookup and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid       <= '0;
            gvalid           <= '0;
            for (int i = 0; i < NUM_WF; i++) begin
                slot_wgid[i] <= '0;
                gtag[i]      <= '0;
                gcount[i]    <= '0;
                ghalted[i]   <= '0;
            end
            bus.rd_valid     <= 1'b0;
            bus.rd_wgid      <= '0;
            bus.rd_wf_count  <= '0;
            bus.wg_done      <= 1'b0;
            bus.wg_done_wgid <= '0;
            bus.wr_err       <= 1'b0;
        end else begin
            if (h_ok) begin
                slot_valid[bus.halt_wfid] <= 1'b0;
            end
            if ((a_kind == ALLOC_HIT) || (a_kind == ALLOC_MISS)) begin
                slot_valid[bus.wr_wfid] <= 1'b1;
                slot_wgid[bus.wr_wfid]  <= w_wgid;
            end
            if (a_kind == ALLOC_MISS) begin
                gtag[bus.wr_wfid]   <= wr_key;
                gcount[bus.wr_wfid] <= bus.wr_wg_wf_count;
            end
            gvalid <= gvalid_n;
            for (int i = 0; i < NUM_WF; i++) begin
                ghalted[i] <= ghalted_n[i];
            end
            bus.rd_valid     <= r_valid;
            bus.rd_wgid      <= r_valid ? slot_wgid[bus.rd_wfid] : '0;
            bus.rd_wf_count  <= r_valid ? gcount[slot_wgid[bus.rd_wfid]] : '0;
            bus.wg_done      <= h_done;
            bus.wg_done_wgid <= h_done ? h_grp : '0;
            bus.wr_err       <= (a_kind == ALLOC_ERR);
        end
    end

`ifdef WAVEGRP_BARRIER_EN
    // Barrier arrival counters and release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                garrive[i] <= '0;
            end
            bus.barrier_release <= 1'b0;
            bus.barrier_wgid    <= '0;
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                garrive[i] <= garrive_n[i];
            end
            bus.barrier_release <= rel_hit;
            bus.barrier_wgid    <= rel_hit ? rel_grp : '0;
        end
    end
`endif

endmodule

// File: tb/tb_wavegrp_tracker.sv
// Self-checking bench for wavegrp_tracker: scenario tasks drive stimulus and
// push expected pulses/lookups to queues; monitors pop and compare.
module tb_wavegrp_tracker;
    import wavegrp_tracker_pkg::*;

    localparam int NUM_WF   = 40;
    localparam int WFID_W   = 6;
    localparam int TAG_W    = 15;
    localparam int WG_TAG_W = 11;
    localparam int CNT_W    = 4;
    localparam int RD_W     = 1 + WFID_W + CNT_W;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [WFID_W-1:0] exp_done_q[$];
    logic [WFID_W-1:0] exp_rel_q[$];
    logic [RD_W-1:0]   exp_rd_q[$];
    logic              rd_issue = 1'b0;
    logic              rd_track = 1'b0;
    logic [WFID_W-1:0] mon_done_e, mon_rel_e;
    logic [RD_W-1:0]   mon_rd_e, mon_rd_got;

    // Clock and DUT
    always #5 clk = ~clk;

    wavegrp_tracker_if #(.WFID_W(WFID_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    wavegrp_tracker #(
        .NUM_WF   (NUM_WF),
        .WFID_W   (WFID_W),
        .TAG_W    (TAG_W),
        .WG_TAG_W (WG_TAG_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wf_wr_en   = 1'b0;
        bus.halt       = 1'b0;
        bus.barrier_en = 1'b0;
        rd_issue       = 1'b0;
    endtask

    task automatic set_alloc(input int id, input int key, input int cnt);
        bus.wf_wr_en       = 1'b1;
        bus.wr_wfid        = WFID_W'(id);
        bus.wr_wf_tag      = TAG_W'(key) << (TAG_W - WG_TAG_W);
        bus.wr_wg_wf_count = CNT_W'(cnt);
    endtask

    task automatic set_halt(input int id, input bit exp_done, input int wgid);
        bus.halt      = 1'b1;
        bus.halt_wfid = WFID_W'(id);
        if (exp_done) exp_done_q.push_back(WFID_W'(wgid));
    endtask

    task automatic set_barrier(input int id);
        bus.barrier_en   = 1'b1;
        bus.barrier_wfid = WFID_W'(id);
    endtask

    task automatic set_read(input int id, input bit v, input int w, input int c);
        exp_rd_q.push_back({v, WFID_W'(w), CNT_W'(c)});
        bus.rd_wfid = WFID_W'(id);
        rd_issue    = 1'b1;
    endtask

    // Scoreboard monitors
    always @(posedge clk) rd_track <= rd_issue;

    always @(negedge clk) begin
        if (bus.wg_done === 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL wg_done_pulse: got pulse wgid=%0d, expected no pulse", bus.wg_done_wgid);
            end else begin
                mon_done_e = exp_done_q.pop_front();
                if (bus.wg_done_wgid !== mon_done_e) begin
                    errors++;
                    $display("FAIL wg_done_wgid: got %0d expected %0d", bus.wg_done_wgid, mon_done_e);
                end
            end
        end
        if (bus.barrier_release === 1'b1) begin
            checks++;
            if (exp_rel_q.size() == 0) begin
                errors++;
                $display("FAIL barrier_pulse: got pulse wgid=%0d, expected no pulse", bus.barrier_wgid);
            end else begin
                mon_rel_e = exp_rel_q.pop_front();
                if (bus.barrier_wgid !== mon_rel_e) begin
                    errors++;
                    $display("FAIL barrier_wgid: got %0d expected %0d", bus.barrier_wgid, mon_rel_e);
                end
            end
        end
        if (rd_track) begin
            checks++;
            mon_rd_got = {bus.rd_valid, bus.rd_wgid, bus.rd_wf_count};
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_queue: got read result with nothing expected");
            end else begin
                mon_rd_e = exp_rd_q.pop_front();
                if (mon_rd_got !== mon_rd_e) begin
                    errors++;
                    $display("FAIL read: got valid=%b wgid=%0d cnt=%0d expected valid=%b wgid=%0d cnt=%0d",
                             mon_rd_got[RD_W-1], mon_rd_got[CNT_W +: WFID_W], mon_rd_got[CNT_W-1:0],
                             mon_rd_e[RD_W-1], mon_rd_e[CNT_W +: WFID_W], mon_rd_e[CNT_W-1:0]);
                end
            end
        end
    end

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.wr_wfid = '0; bus.wr_wf_tag = '0; bus.wr_wg_wf_count = '0;
        bus.halt_wfid = '0; bus.barrier_wfid = '0; bus.rd_wfid = '0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_wgid, bus.rd_wf_count} !== '0) begin
            errors++;
            $display("FAIL reset_rd: got %b expected 0", {bus.rd_valid, bus.rd_wgid, bus.rd_wf_count});
        end
        checks++;
        if ({bus.wg_done, bus.wg_done_wgid, bus.wr_err, bus.barrier_release, bus.barrier_wgid} !== '0) begin
            errors++;
            $display("FAIL reset_pulses: got done=%b err=%b rel=%b expected 0", bus.wg_done, bus.wr_err, bus.barrier_release);
        end
        set_read(3, 1'b0, 0, 0); step(); clear_inputs();
    endtask

    task automatic test_alloc_read();
        set_alloc(3, 'h12, 2); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL alloc3_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        // read in the same cycle as the write sees the old (empty) slot
        set_alloc(7, 'h12, 2); set_read(7, 1'b0, 0, 0); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL alloc7_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        set_read(7, 1'b1, 3, 2); step(); clear_inputs();
        set_read(3, 1'b1, 3, 2); step(); clear_inputs();
    endtask

    task automatic test_halt_done();
        set_halt(3, 1'b0, 0); step(); clear_inputs();
        set_read(3, 1'b0, 0, 0); step(); clear_inputs();
        set_halt(7, 1'b1, 3); step(); clear_inputs();
        step();
        checks++;
        if (exp_done_q.size() != 0) begin errors++; $display("FAIL halt_done_drain: got %0d pending expected 0", exp_done_q.size()); end
        // key 0x12 no longer live: this opens group 8
        set_alloc(8, 'h12, 1); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL realloc_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        set_read(8, 1'b1, 8, 1); set_halt(8, 1'b1, 8); step(); clear_inputs();
        set_read(8, 1'b0, 0, 0); step(); clear_inputs();
        step();
        checks++;
        if (exp_done_q.size() != 0) begin errors++; $display("FAIL single_done_drain: got %0d pending expected 0", exp_done_q.size()); end
    endtask

    task automatic test_errors();
        set_alloc(5, 'h30, 3); step(); clear_inputs();
        set_alloc(5, 'h31, 1); step();
        checks++;
        if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_slot_valid: got %b expected 1", bus.wr_err); end
        clear_inputs();
        set_read(5, 1'b1, 5, 3); step(); clear_inputs();
        set_alloc(6, 'h40, 0); step();
        checks++;
        if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_count0: got %b expected 1", bus.wr_err); end
        clear_inputs();
        set_read(6, 1'b0, 0, 0); step(); clear_inputs();
        set_halt(5, 1'b0, 0); step(); clear_inputs();
        set_alloc(5, 'h41, 1); step();
        checks++;
        if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_group_live: got %b expected 1", bus.wr_err); end
        clear_inputs();
        set_alloc(6, 'h30, 0); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL hit_count0_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        set_read(6, 1'b1, 5, 3); step(); clear_inputs();
        set_halt(6, 1'b0, 0); step(); clear_inputs();
        set_alloc(10, 'h30, 0); step(); clear_inputs();
        set_halt(10, 1'b1, 5); step(); clear_inputs();
        step();
        checks++;
        if (exp_done_q.size() != 0) begin errors++; $display("FAIL err_group_drain: got %0d pending expected 0", exp_done_q.size()); end
    endtask

    task automatic test_same_cycle();
        set_alloc(9, 'h50, 1); step(); clear_inputs();
        set_halt(9, 1'b1, 9); set_alloc(9, 'h20, 1); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL same_slot_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        set_read(9, 1'b1, 9, 1); step(); clear_inputs();
        repeat (2) step();
        // completing group must not capture a same-cycle allocate with its key
        set_alloc(12, 'h60, 1); step(); clear_inputs();
        set_halt(12, 1'b1, 12); set_alloc(13, 'h60, 2); step();
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL cam_mask_err: got %b expected 0", bus.wr_err); end
        clear_inputs();
        set_read(13, 1'b1, 13, 2); step(); clear_inputs();
        set_halt(9, 1'b1, 9); set_alloc(14, 'h60, 0); step(); clear_inputs();
        set_read(14, 1'b1, 13, 2); step(); clear_inputs();
        set_read(9, 1'b0, 0, 0); step(); clear_inputs();
        set_halt(13, 1'b0, 0); step(); clear_inputs();
        set_halt(14, 1'b1, 13); step(); clear_inputs();
        step();
        checks++;
        if (exp_done_q.size() != 0) begin errors++; $display("FAIL same_cycle_drain: got %0d pending expected 0", exp_done_q.size()); end
    endtask

    task automatic test_barrier();
        set_alloc(20, 'h70, 3); step(); clear_inputs();
        set_alloc(21, 'h70, 3); step(); clear_inputs();
        set_alloc(22, 'h70, 3); step(); clear_inputs();
        set_barrier(20); step();
        checks++;
        if (bus.barrier_release !== 1'b0) begin errors++; $display("FAIL barrier_early1: got %b expected 0", bus.barrier_release); end
        clear_inputs();
        set_barrier(21); step();
        checks++;
        if (bus.barrier_release !== 1'b0) begin errors++; $display("FAIL barrier_early2: got %b expected 0", bus.barrier_release); end
        clear_inputs();
        set_halt(22, 1'b0, 0);
`ifdef WAVEGRP_BARRIER_EN
        exp_rel_q.push_back(WFID_W'(20));
`endif
        step();
`ifndef WAVEGRP_BARRIER_EN
        checks++;
        if ({bus.barrier_release, bus.barrier_wgid} !== '0) begin
            errors++;
            $display("FAIL barrier_off: got rel=%b wgid=%0d expected 0", bus.barrier_release, bus.barrier_wgid);
        end
`endif
        clear_inputs();
        set_halt(20, 1'b0, 0); step(); clear_inputs();
        set_halt(21, 1'b1, 20); step(); clear_inputs();
        step();
        checks++;
        if (exp_rel_q.size() + exp_done_q.size() != 0) begin
            errors++;
            $display("FAIL barrier_drain: got %0d pending expected 0", exp_rel_q.size() + exp_done_q.size());
        end
    endtask

    bit model_v [NUM_WF];

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int s;
            s = $urandom_range(39, 32);
            if (!model_v[s]) begin
                set_alloc(s, 'h100 + i, 1); step();
                checks++;
                if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL rand_alloc_err slot %0d: got %b expected 0", s, bus.wr_err); end
                clear_inputs();
                model_v[s] = 1'b1;
            end else begin
                set_halt(s, 1'b1, s); set_read(s, 1'b1, s, 1); step(); clear_inputs();
                model_v[s] = 1'b0;
            end
        end
        step();
        checks++;
        if (exp_done_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending expected 0", exp_done_q.size()); end
    endtask

    task automatic test_reset_mid();
        set_alloc(30, 'h7A, 2); step(); clear_inputs();
        set_alloc(31, 'h7A, 2); step(); clear_inputs();
        set_halt(30, 1'b0, 0); step(); clear_inputs();
        // reset lands on the edge that would register the completion
        set_halt(31, 1'b0, 0); rst = 1'b1; step(); clear_inputs();
        rst = 1'b0;
        step();
        checks++;
        if (bus.wg_done !== 1'b0) begin errors++; $display("FAIL reset_drop_done: got %b expected 0", bus.wg_done); end
        for (int i = 0; i < NUM_WF; i++) begin
            set_read(i, 1'b0, 0, 0); step(); clear_inputs();
        end
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_alloc_read();
        test_halt_done();
        test_errors();
        test_same_cycle();
        test_barrier();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_rd_q.size() + exp_done_q.size() + exp_rel_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending expected 0", exp_rd_q.size() + exp_done_q.size() + exp_rel_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
